uart_rx_fifo_param: RTL

Parametrised receive FIFO for the UART RX path; stores received characters together with their per-character error flags (parity, framing, break).
- Upstream: the UART receiver. Downstream: the APB register interface.
- Adds over the current RX buffer: an explicit read handshake, simultaneous read/write, synchronous flush, programmable level interrupt, sticky overrun flag and sticky error summary.

---
 rtl/uart_rx_fifo_param_if.sv | 31 +++
 rtl/uart_rx_fifo_param.sv | 58 +++++
 2 files changed

// File: rtl/uart_rx_fifo_param_if.sv
// uart_rx_fifo_param_if: receiver-side write, APB-side read and status signals of the RX FIFO.
interface uart_rx_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 3,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = DATA_W + ERR_W;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          flush;
    logic [AW:0]   thresh;
    logic          clr_status;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          level_irq;
    logic          overrun;
    logic [ERR_W-1:0] err_seen;
    modport master (
        output wr_en, wr_data, rd_en, flush, thresh, clr_status,
        input  rd_data, rd_valid, count, empty, full, level_irq, overrun, err_seen
    );
    modport slave (
        input  wr_en, wr_data, rd_en, flush, thresh, clr_status,
        output rd_data, rd_valid, count, empty, full, level_irq, overrun, err_seen
    );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: RX character FIFO with per-entry error flags, flush, level interrupt and sticky status.
module uart_rx_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 3,
    parameter int DEPTH  = 32
) (
    input logic clk,
    input logic reset,
    uart_rx_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = DATA_W + ERR_W;
    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic [W-1:0]     rd_data;
    logic             rd_valid, overrun;
    logic [ERR_W-1:0] err_seen, err_set;
    logic             empty, full, rd_acc, wr_acc, ovf_set;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    // flush masks both sides so nothing moves and no overrun is flagged in that cycle
    assign rd_acc  = bus.rd_en && !empty && !bus.flush;
    assign wr_acc  = bus.wr_en && (!full || rd_acc) && !bus.flush;
    assign ovf_set = bus.wr_en && full && !rd_acc && !bus.flush;
    assign err_set = wr_acc ? bus.wr_data[W-1:DATA_W] : '0;
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
            err_seen <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr];
            wr_ptr   <= bus.flush ? '0 : wr_acc ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= bus.flush ? '0 : rd_acc ? rd_ptr + AW'(1) : rd_ptr;
            cnt      <= bus.flush ? '0 : (wr_acc && !rd_acc) ? cnt + (AW+1)'(1) :
                        (rd_acc && !wr_acc) ? cnt - (AW+1)'(1) : cnt;
            overrun  <= (overrun && !bus.clr_status) || ovf_set;
            err_seen <= (bus.clr_status ? '0 : err_seen) | err_set;
        end
    end
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.count     = cnt;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.level_irq = (bus.thresh != '0) && (cnt >= bus.thresh);
    assign bus.overrun   = overrun;
    assign bus.err_seen  = err_seen;
endmodule
